// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, FSM states,
// ALU operations and the instruction legality check.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6
    } alu_op_t;

    // Anything outside the supported subset stops the core.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL, FN_JR: ok = 1'b1;
                    default: ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Instruction and data memory valid/ready buses of the multi-cycle MIPS core.
interface mips_multicycle_core_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mips_alu.sv
// Combinational ALU for the multi-cycle MIPS core; zero flag drives beq/bne.
module mips_alu
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    // Result select; shifts operate on b (rt) by the instruction shamt.
    always_comb begin
        y = {DATA_W{1'b0}};
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL: y = b << shamt;
            ALU_SRL: y = b >> shamt;
            default: y = {DATA_W{1'b0}};
        endcase
    end

    assign zero = (y == {DATA_W{1'b0}});

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS integer core: owns PC, register file and the
// FETCH/DECODE/EXEC/MEM/WB sequencing over valid/ready memory ports.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int NREGS  = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    mips_multicycle_core_if.master    bus,
    output logic [ADDR_W-1:0]         pc,
    output logic                      halted
);

    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t            state_r, state_n;
    logic [31:0]       ir_r;
    logic [ADDR_W-1:0] pc_r;
    logic [DATA_W-1:0] a_r, b_r, imm_r, alu_out_r, mdr_r;
    logic [DATA_W-1:0] regs_r [NREGS];

    logic              imem_req_r, dmem_req_r, dmem_we_r, halted_r;
    logic [ADDR_W-1:0] dmem_addr_r;
    logic [DATA_W-1:0] dmem_wdata_r;

    logic [5:0]        op_s, funct_s;
    logic [RW-1:0]     rs_s, rt_s, rd_s, wb_idx_s;
    logic              is_rtype_s, is_jr_s, is_j_s, is_beq_s, is_bne_s, is_branch_s;
    logic              is_lw_s, is_sw_s, legal_s, taken_s;
    logic              fetch_done_s, mem_done_s;
    logic [DATA_W-1:0] rs_val_s, rt_val_s, imm_sext_s, wb_data_s;
    logic [ADDR_W-1:0] jump_target_s, br_off_s, pc_inc_s, br_target_s;
    alu_op_t           alu_op_s;
    logic [DATA_W-1:0] alu_b_s, alu_y_s;
    logic              alu_zero_s;

    assign op_s        = ir_r[31:26];
    assign funct_s     = ir_r[5:0];
    assign rs_s        = ir_r[21 +: RW];
    assign rt_s        = ir_r[16 +: RW];
    assign rd_s        = ir_r[11 +: RW];
    assign is_rtype_s  = (op_s == OP_RTYPE);
    assign is_jr_s     = is_rtype_s && (funct_s == FN_JR);
    assign is_j_s      = (op_s == OP_J);
    assign is_beq_s    = (op_s == OP_BEQ);
    assign is_bne_s    = (op_s == OP_BNE);
    assign is_branch_s = is_beq_s || is_bne_s;
    assign is_lw_s     = (op_s == OP_LW);
    assign is_sw_s     = (op_s == OP_SW);
    assign legal_s     = is_legal(op_s, funct_s);

    assign rs_val_s    = (rs_s == {RW{1'b0}}) ? {DATA_W{1'b0}} : regs_r[rs_s];
    assign rt_val_s    = (rt_s == {RW{1'b0}}) ? {DATA_W{1'b0}} : regs_r[rt_s];
    assign imm_sext_s  = {{(DATA_W-16){ir_r[15]}}, ir_r[15:0]};

    // Fit the 26-bit jump field and the 16-bit branch offset to the PC width.
    generate
        if (ADDR_W > 26) begin : g_jmp_wide
            assign jump_target_s = {{(ADDR_W-26){1'b0}}, ir_r[25:0]};
        end else begin : g_jmp_narrow
            assign jump_target_s = ir_r[ADDR_W-1:0];
        end
        if (ADDR_W > 16) begin : g_br_wide
            assign br_off_s = {{(ADDR_W-16){ir_r[15]}}, ir_r[15:0]};
        end else begin : g_br_narrow
            assign br_off_s = ir_r[ADDR_W-1:0];
        end
    endgenerate

    assign pc_inc_s     = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign br_target_s  = pc_inc_s + br_off_s;
    assign taken_s      = is_beq_s ? alu_zero_s : !alu_zero_s;
    assign fetch_done_s = imem_req_r && bus.imem_ready;
    assign mem_done_s   = dmem_req_r && bus.dmem_ready;
    assign wb_idx_s     = is_rtype_s ? rd_s : rt_s;
    assign wb_data_s    = is_lw_s ? mdr_r : alu_out_r;

    // ALU operand and operation selection for the EXEC state.
    always_comb begin
        alu_op_s = ALU_ADD;
        alu_b_s  = imm_r;
        if (is_rtype_s) begin
            alu_b_s = b_r;
            case (funct_s)
                FN_ADD:  alu_op_s = ALU_ADD;
                FN_SUB:  alu_op_s = ALU_SUB;
                FN_AND:  alu_op_s = ALU_AND;
                FN_OR:   alu_op_s = ALU_OR;
                FN_SLT:  alu_op_s = ALU_SLT;
                FN_SLL:  alu_op_s = ALU_SLL;
                FN_SRL:  alu_op_s = ALU_SRL;
                default: alu_op_s = ALU_ADD;
            endcase
        end else if (is_branch_s) begin
            alu_b_s  = b_r;
            alu_op_s = ALU_SUB;
        end else begin
            alu_b_s  = imm_r;
            alu_op_s = ALU_ADD;
        end
    end

    mips_alu #(.DATA_W(DATA_W)) u_alu (
        .a     (a_r),
        .b     (alu_b_s),
        .shamt (ir_r[10:6]),
        .op    (alu_op_s),
        .y     (alu_y_s),
        .zero  (alu_zero_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_r <= ST_FETCH;
        else          state_r <= state_n;
    end

    // FSM next-state logic; memory states wait for ready on an issued request.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_FETCH:  begin
                if (fetch_done_s) state_n = ST_DECODE;
                else              state_n = ST_FETCH;
            end
            ST_DECODE: begin
                if (!legal_s)                 state_n = ST_HALT;
                else if (is_j_s || is_jr_s)   state_n = ST_FETCH;
                else                          state_n = ST_EXEC;
            end
            ST_EXEC:   begin
                if (is_branch_s)              state_n = ST_FETCH;
                else if (is_lw_s || is_sw_s)  state_n = ST_MEM;
                else                          state_n = ST_WB;
            end
            ST_MEM:    begin
                if (!mem_done_s)   state_n = ST_MEM;
                else if (is_sw_s)  state_n = ST_FETCH;
                else               state_n = ST_WB;
            end
            ST_WB:     state_n = ST_FETCH;
            ST_HALT:   state_n = ST_HALT;
            default:   state_n = ST_HALT;
        endcase
    end

    // Request/status outputs are registered from the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            imem_req_r <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            imem_req_r <= (state_n == ST_FETCH);
            dmem_req_r <= (state_n == ST_MEM);
            dmem_we_r  <= (state_n == ST_MEM) && is_sw_s;
            halted_r   <= (state_n == ST_HALT);
        end
    end

    // Datapath registers: IR, operands, ALU result, MDR, PC and data-port address/data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir_r         <= 32'h0000_0000;
            pc_r         <= {ADDR_W{1'b0}};
            a_r          <= {DATA_W{1'b0}};
            b_r          <= {DATA_W{1'b0}};
            imm_r        <= {DATA_W{1'b0}};
            alu_out_r    <= {DATA_W{1'b0}};
            mdr_r        <= {DATA_W{1'b0}};
            dmem_addr_r  <= {ADDR_W{1'b0}};
            dmem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (fetch_done_s) ir_r <= bus.imem_rdata;
                end
                ST_DECODE: begin
                    a_r   <= rs_val_s;
                    b_r   <= rt_val_s;
                    imm_r <= imm_sext_s;
                    if (legal_s && is_j_s)  pc_r <= jump_target_s;
                    if (legal_s && is_jr_s) pc_r <= rs_val_s[ADDR_W-1:0];
                end
                ST_EXEC: begin
                    alu_out_r <= alu_y_s;
                    if (is_branch_s) pc_r <= taken_s ? br_target_s : pc_inc_s;
                    if (is_lw_s || is_sw_s) begin
                        dmem_addr_r  <= alu_y_s[ADDR_W-1:0];
                        dmem_wdata_r <= b_r;
                    end
                end
                ST_MEM: begin
                    if (mem_done_s && is_lw_s) mdr_r <= bus.dmem_rdata;
                    if (mem_done_s && is_sw_s) pc_r  <= pc_inc_s;
                end
                ST_WB:   pc_r <= pc_inc_s;
                ST_HALT: pc_r <= pc_r;
                default: pc_r <= pc_r;
            endcase
        end
    end

    // Register file; entry 0 is never written so it always reads as zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_r[i] <= {DATA_W{1'b0}};
        end else if ((state_r == ST_WB) && (wb_idx_s != {RW{1'b0}})) begin
            regs_r[wb_idx_s] <= wb_data_s;
        end
    end

    assign bus.imem_req   = imem_req_r;
    assign bus.imem_addr  = pc_r;
    assign bus.dmem_req   = dmem_req_r;
    assign bus.dmem_we    = dmem_we_r;
    assign bus.dmem_addr  = dmem_addr_r;
    assign bus.dmem_wdata = dmem_wdata_r;
    assign pc             = pc_r;
    assign halted         = halted_r;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: wait-state memory models plus
// fetch/store scoreboards checked against hand-computed programs.
module tb_mips_multicycle_core;
    import mips_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int NREGS  = 32;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    mips_multicycle_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mips_multicycle_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .pc      (pc),
        .halted  (halted)
    );

    initial forever #5 clock = ~clock;

    typedef struct { int pc; int gap; } fetch_exp_t;
    typedef struct { int addr; logic [31:0] data; } store_exp_t;

    fetch_exp_t  fetch_q [$];
    store_exp_t  store_q [$];
    logic [31:0] imem [int];
    logic [31:0] dmem [int];
    logic [31:0] prog [$];
    int          lat  [$];
    int          tests = 0, fails = 0;
    int          imem_wait = 0, dmem_wait = 0, cyc = 0, last_acc = 0;
    bit          strict = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, logic [5:0] fn);
        return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic add_instr(input logic [31:0] w, input int l);
        prog.push_back(w);
        lat.push_back(l);
    endtask

    task automatic exp_fetch(input int p, input int g);
        fetch_exp_t e;
        e.pc = p; e.gap = g;
        fetch_q.push_back(e);
    endtask

    task automatic exp_store(input int a, input logic [31:0] d);
        store_exp_t s;
        s.addr = a; s.data = d;
        store_q.push_back(s);
    endtask

    // Memory models: ready rises after the programmed number of wait cycles.
    initial begin
        int icnt, dcnt, gap;
        fetch_exp_t e;
        store_exp_t s;
        icnt = 0; dcnt = 0;
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
        bus.dmem_ready = 1'b0; bus.dmem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            cyc++;
            if (bus.imem_req && !bus.imem_ready) begin
                if (icnt >= imem_wait) begin
                    bus.imem_ready = 1'b1;
                    bus.imem_rdata = imem.exists(int'(bus.imem_addr)) ? imem[int'(bus.imem_addr)] : 32'h0;
                    gap = cyc - last_acc;
                    last_acc = cyc;
                    icnt = 0;
                    if (fetch_q.size() > 0) begin
                        e = fetch_q.pop_front();
                        check("fetch_pc", 64'(bus.imem_addr), 64'(e.pc));
                        if (e.gap > 0) check("fetch_gap", 64'(gap), 64'(e.gap));
                    end else if (strict) begin
                        check("fetch_unexpected", 64'(bus.imem_addr), 64'hFFFF_FFFF);
                    end
                end else begin
                    icnt++;
                end
            end else begin
                bus.imem_ready = 1'b0;
                icnt = 0;
            end
            if (bus.dmem_req && !bus.dmem_ready) begin
                if (dcnt >= dmem_wait) begin
                    bus.dmem_ready = 1'b1;
                    dcnt = 0;
                    if (bus.dmem_we) begin
                        dmem[int'(bus.dmem_addr)] = bus.dmem_wdata;
                        tests++;
                        assert (store_q.size() > 0) else begin
                            fails++;
                            $error("FAIL store_unexpected: observed addr %0h expected no store", bus.dmem_addr);
                        end
                        if (store_q.size() > 0) begin
                            s = store_q.pop_front();
                            check("store_addr", 64'(bus.dmem_addr), 64'(s.addr));
                            check("store_data", 64'(bus.dmem_wdata), 64'(s.data));
                        end
                    end else begin
                        bus.dmem_rdata = dmem.exists(int'(bus.dmem_addr)) ? dmem[int'(bus.dmem_addr)] : 32'h0;
                    end
                end else begin
                    dcnt++;
                end
            end else begin
                bus.dmem_ready = 1'b0;
                dcnt = 0;
            end
        end
    end

    task automatic begin_test(input int iw, input int dw, input bit st);
        reset_n = 1'b0;
        @(negedge clock);
        imem.delete(); dmem.delete(); prog.delete(); lat.delete();
        fetch_q.delete(); store_q.delete();
        imem_wait = iw; dmem_wait = dw; strict = st;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) begin
            imem[i] = prog[i];
            exp_fetch(i, (i == 0) ? 0 : lat[i-1]);
        end
    endtask

    task automatic end_test(input int ncyc);
        repeat (ncyc) @(negedge clock);
        check("fetch_q_drained", 64'(fetch_q.size()), 64'd0);
        check("store_q_drained", 64'(store_q.size()), 64'd0);
    endtask

    initial begin
        // Reset values, then a reset while a fetch is stalled.
        reset_n = 1'b0;
        imem_wait = 1000;
        repeat (2) @(negedge clock);
        check("rst_imem_req", 64'(bus.imem_req), 64'd0);
        check("rst_dmem_req", 64'(bus.dmem_req), 64'd0);
        check("rst_dmem_we", 64'(bus.dmem_we), 64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
        check("rst_dmem_addr", 64'(bus.dmem_addr), 64'd0);
        check("rst_dmem_wdata", 64'(bus.dmem_wdata), 64'd0);
        check("rst_pc", 64'(pc), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("fetch_req_held", 64'(bus.imem_req), 64'd1);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check("req_drop_async", 64'(bus.imem_req), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_pc", 64'(pc), 64'd0);
        check("post_rst_halted", 64'(halted), 64'd0);

        // ALU ops, r0 write discard, sw/lw with 3 data wait states, then halt.
        begin_test(0, 3, 1'b1);
        add_instr(enc_i(OP_ADDI, 0, 1, 5), 4);
        add_instr(enc_i(OP_ADDI, 0, 2, -3), 4);
        add_instr(enc_r(1, 2, 3, 0, FN_ADD), 4);
        add_instr(enc_r(2, 1, 4, 0, FN_SLT), 4);
        add_instr(enc_r(2, 1, 6, 0, FN_SUB), 4);
        add_instr(enc_r(1, 2, 7, 0, FN_AND), 4);
        add_instr(enc_r(1, 2, 8, 0, FN_OR), 4);
        add_instr(enc_r(0, 1, 9, 3, FN_SLL), 4);
        add_instr(enc_r(0, 2, 10, 28, FN_SRL), 4);
        add_instr(enc_r(1, 2, 11, 0, FN_SLT), 4);
        add_instr(enc_r(1, 1, 0, 0, FN_ADD), 4);
        add_instr(enc_i(OP_SW, 0, 1, 4), 7);
        add_instr(enc_i(OP_LW, 0, 5, 4), 8);
        add_instr(enc_i(OP_SW, 0, 3, 16), 7);
        add_instr(enc_i(OP_SW, 0, 4, 17), 7);
        add_instr(enc_i(OP_SW, 0, 6, 18), 7);
        add_instr(enc_i(OP_SW, 0, 7, 19), 7);
        add_instr(enc_i(OP_SW, 0, 8, 20), 7);
        add_instr(enc_i(OP_SW, 0, 9, 21), 7);
        add_instr(enc_i(OP_SW, 0, 10, 22), 7);
        add_instr(enc_i(OP_SW, 0, 11, 23), 7);
        add_instr(enc_i(OP_SW, 0, 0, 24), 7);
        add_instr(enc_i(OP_SW, 0, 5, 25), 7);
        add_instr(enc_i(OP_ADDI, 0, 12, -1), 4);
        add_instr(enc_r(12, 12, 13, 0, FN_ADD), 4);
        add_instr(enc_i(OP_SW, 0, 13, 26), 7);
        add_instr(32'hFC00_0000, 0);
        load_prog();
        exp_store(4, 32'd5);
        exp_store(16, 32'd2);
        exp_store(17, 32'd1);
        exp_store(18, 32'hFFFF_FFF8);
        exp_store(19, 32'd5);
        exp_store(20, 32'hFFFF_FFFD);
        exp_store(21, 32'd40);
        exp_store(22, 32'hF);
        exp_store(23, 32'd0);
        exp_store(24, 32'd0);
        exp_store(25, 32'd5);
        exp_store(26, 32'hFFFF_FFFE);
        @(negedge clock);
        reset_n = 1'b1;
        end_test(260);
        check("halt_flag", 64'(halted), 64'd1);
        check("halt_no_req", 64'(bus.imem_req), 64'd0);
        check("halt_pc", 64'(pc), 64'd26);

        // Branches with one fetch wait state: bne not taken, bne taken, beq self-loop.
        begin_test(1, 0, 1'b0);
        imem[0]  = enc_i(OP_ADDI, 0, 1, 5);
        imem[1]  = enc_i(OP_BNE, 1, 1, 2);
        imem[2]  = enc_i(OP_BNE, 1, 0, 7);
        imem[10] = enc_i(OP_BEQ, 1, 1, -1);
        exp_fetch(0, 0);
        exp_fetch(1, 5);
        exp_fetch(2, 4);
        exp_fetch(10, 4);
        exp_fetch(10, 4);
        exp_fetch(10, 4);
        @(negedge clock);
        reset_n = 1'b1;
        end_test(50);
        check("beq_loop_pc", 64'(pc), 64'd10);

        // jr, j to the PC ceiling and PC wrap through a branch at 0xFFFF.
        begin_test(0, 0, 1'b0);
        imem[0]      = enc_i(OP_ADDI, 0, 1, 5);
        imem[1]      = enc_r(1, 0, 0, 0, FN_JR);
        imem[5]      = {OP_J, 26'h3FF_FFFF};
        imem[16'hFFFF] = enc_i(OP_BEQ, 0, 0, 0);
        exp_fetch(0, 0);
        exp_fetch(1, 4);
        exp_fetch(5, 2);
        exp_fetch(16'hFFFF, 2);
        exp_fetch(0, 3);
        exp_fetch(1, 4);
        @(negedge clock);
        reset_n = 1'b1;
        end_test(30);

        // Unknown funct under op 0 halts with no further traffic.
        begin_test(0, 0, 1'b1);
        imem[0] = enc_r(0, 0, 0, 0, 6'h3F);
        exp_fetch(0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        end_test(20);
        check("bad_funct_halted", 64'(halted), 64'd1);
        check("bad_funct_pc", 64'(pc), 64'd0);
        check("bad_funct_dmem_req", 64'(bus.dmem_req), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle successor to the single-cycle MIPS core. It executes the same MIPS integer subset through a five-state FSM instead of one long combinational path. It adds an asynchronous active-low reset, valid/ready handshakes to separate instruction and data memories (so wait states are tolerated), and a halt on illegal opcodes. It sits at the top of the MIPS datapath and owns the PC, the register file and sequencing; the memories are external.

## Interface
- DATA_W, 32: datapath and register width (≥ 32; instruction word is always 32 bits).
- ADDR_W, 16: word-address width of both memory ports and PC.
- NREGS, 32: register count (power of two, ≤ 32; register fields use the low log2(NREGS) bits).
- clock  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction-fetch request.
- imem_addr  out  ADDR_W  fetch word address (= PC).
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data word address.
- dmem_wdata  out  DATA_W  store data (rt).
- dmem_ready  in  1  data access complete; dmem_rdata valid on load.
- dmem_rdata  in  DATA_W  load data.
- pc  out  ADDR_W  current PC.
- halted  out  1  core stopped on illegal opcode.

## Operation
- Supported instructions:
  - R-type (op 0x00), by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00, srl 0x02, jr 0x08.
  - I-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - J-type: j 0x02.
  - Any other op, or an unknown funct under op 0x00 → HALT.
- States and transitions:
  - FETCH: hold imem_req=1, imem_addr=PC until imem_ready. On ready, latch IR → DECODE.
  - DECODE: read rs/rt into A/B; sign-extend imm16 to DATA_W. Illegal instruction → HALT. j → PC=zero-extended/truncated address26, FETCH. jr → PC=A[ADDR_W-1:0], FETCH. Otherwise → EXEC.
  - EXEC: ALU. beq/bne → PC=PC+1+sext(imm) if taken (equal for beq, not equal for bne), else PC+1; then FETCH. lw/sw → ALUOut=A+sext(imm), MEM. R-type/addi → WB.
  - MEM: hold dmem_req=1, dmem_addr=ALUOut[ADDR_W-1:0], dmem_we=(sw), dmem_wdata=B until dmem_ready. sw → PC+1, FETCH. lw → latch MDR, WB.
  - WB: write ALUOut (R-type: rd; addi: rt) or MDR (lw: rt); PC=PC+1; FETCH.
  - HALT: terminal until reset; halted=1, no requests issued.
- Register 0 reads 0; writes to it are discarded.
- All arithmetic wraps modulo 2^DATA_W; no overflow traps. PC wraps modulo 2^ADDR_W. Shifts use shamt (5 bits) on rt.

## Timing
- Reset (asynchronous assert, synchronous deassert by the integrator): PC=0, state=FETCH, all registers 0, imem_req=dmem_req=dmem_we=0, halted=0, addresses/wdata 0.
- With zero-wait memory (ready in the same cycle as req):
  - j, jr: 2 cycles.
  - beq, bne: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
- Each ready-low cycle adds one cycle.
- req and address stay stable while ready=0. Ready is ignored when req=0.
- Register write and PC update take effect on the WB/last-state edge. The next FETCH uses the new PC.
- Reset asserted mid-access drops req immediately. The outstanding access is abandoned.

## Structure
- Package mips_pkg: opcode and funct localparams, state enum (FETCH, DECODE, EXEC, MEM, WB, HALT), ALU-op enum.
- Sub-module mips_alu (DATA_W parametrised, combinational): add/sub/and/or/slt/sll/srl, plus zero flag.
- Register file is inline in the core.

## Test plan
- Reset mid-FETCH with imem_ready held 0 → imem_req drops at once; pc=0, halted=0 after release.
- addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 → r3=2, r4=1. addi writes r1 in cycle 4.
- sw r1,4(r0) then lw r5,4(r0), with dmem_ready delayed 3 cycles each → dmem_addr=4, wdata=5; r5=5; lw takes 8 cycles.
- beq r1,r1,-1 at PC 10 → PC stays 10; bne r1,r1,+2 → PC 11. j 0x3FFFFFF with ADDR_W=16 → PC 0xFFFF. jr r1 → PC 5.
- Instruction word 0xFC000000 → halted=1 in DECODE; no further imem_req until reset.
- add r0,r1,r1 → r0 still reads 0.
